lfsr32_checker: RTL
===================

// Module: lfsr32_checker
// PURPOSE
//  Receive-side checker for the 32-bit random stream produced by lfsr32.
//  Accepts one word per valid beat and self-synchronises on that stream.
//  Predicts each following word and counts mismatches.
//  Used on the random-point path to catch dropped or duplicated enables and corrupted samples.
// PARAMETERS
//  LOCK_CNT    4   consecutive correct predictions needed to declare lock (>=1)
//  UNLOCK_CNT  3   consecutive mispredictions while locked that drop lock (>=1)
//  ERR_W       16  width of err_count (saturating)
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  data        in   32     received LFSR word
//  valid       in   1      data is a new LFSR step this cycle
//  clear       in   1      synchronous clear of err_count/beat_count only
//  locked      out  1      checker is synchronised to the stream
//  error       out  1      one-cycle pulse: locked-state misprediction
//  err_count   out  ERR_W  mispredictions while locked, saturates at all-ones
//  beat_count  out  32     valid beats checked while locked, wraps
// BEHAVIOUR
//  - nxt(x) = {x[30:0], ~(x[31]^x[21]^x[1]^x[0])}, identical to the lfsr32 step.
//  - Reset: state=HUNT; pred, run, miss, err_count, beat_count = 0; locked=0; error=0.
//  - Cycles without valid: no state or counter change, and error=0.
//  - All outputs are registered. Effects of a valid beat appear one cycle after the beat.
//  - HUNT, on valid:
//      - data==32'hFFFF_FFFF (XNOR lock-up word): stay in HUNT.
//      - otherwise: pred<=nxt(data), run<=0, go to SYNC.
//  - SYNC, on valid:
//      - data==pred: pred<=nxt(data), run<=run+1.
//        If run+1==LOCK_CNT: go to LOCKED, locked<=1, miss<=0.
//      - mismatch: re-seed with pred<=nxt(data) and run<=0; stay in SYNC.
//        If data==all-ones, go to HUNT instead.
//      - No error pulses and no counting in SYNC.
//  - LOCKED, on valid:
//      - Always: pred<=nxt(pred) (free-running, never re-seeded from data); beat_count+1.
//      - match: miss<=0.
//      - mismatch: error<=1 for exactly one cycle; err_count+1 (held at max);
//        miss<=miss+1.
//        If miss+1==UNLOCK_CNT: go to HUNT, locked<=0.
//  - The lock-drop beat itself still counts as an error.
//  - clear has priority over a simultaneous increment: both counters become 0
//    and that beat's increment is lost. clear never affects state, locked or error.
//  - LOCK_CNT beats after the seed word are needed to lock.
//    locked rises one cycle after the LOCK_CNT-th matching beat.
//  - A mid-operation reset overrides all other inputs and returns to the reset values.
// TESTING
//  1 seed lfsr32 with 32'hAAAA_CCCC, drive its q with valid every cycle
//    -> locked=1 after beat 5; nxt(AAAACCCC)=32'h5555_9999; err_count stays 0.
//  2 once locked, replace one word with data^1
//    -> one error pulse, err_count=1, locked stays 1, later words match.
//  3 drop one lfsr enable (stream skips a step) while locked
//    -> 3 consecutive errors, locked=0 after the 3rd; re-locks after 5 more beats.
//  4 feed 32'hFFFF_FFFF repeatedly -> remains in HUNT, locked=0, error never asserted.
//  5 ERR_W=2, 5 corrupted beats spaced apart -> err_count saturates at 3.
//    clear on an error beat -> err_count=0.
//  6 reset asserted while locked, with valid high
//    -> next cycle locked=0, both counters 0, error=0.
//  7 valid gaps of 1-4 cycles in the clean stream -> lock and counts unaffected.

Source files
------------

// File: rtl/lfsr32_checker.sv
// Receive-side checker for the lfsr32 random stream.
// Self-synchronises on the incoming words, then predicts each following word
// and counts mispredictions while locked.
//
// Handshake: there is no back-pressure. A beat is accepted on every posedge
// where valid is high; data is only looked at on those cycles. Cycles without
// valid change nothing (apart from clear acting on the counters), and error
// drops back to 0 on them.
//
// All outputs are registered, so a beat's effect is visible one cycle later.
// dbg_state exposes the FSM state (0=HUNT, 1=SYNC, 2=LOCKED) for observation.
module lfsr32_checker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      data,
   input  logic             valid,
   input  logic             clear,
   output logic             locked,
   output logic             error,
   output logic [ERR_W-1:0] err_count,
   output logic [31:0]      beat_count,
   output logic [1:0]       dbg_state
);

   localparam int          RUN_W    = $clog2(LOCK_CNT + 1);
   localparam int          MISS_W   = $clog2(UNLOCK_CNT + 1);
   localparam logic [31:0] LOCK_U   = LOCK_CNT;
   localparam logic [31:0] UNLOCK_U = UNLOCK_CNT;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // One step of the lfsr32 XNOR generator.
   function automatic logic [31:0] nxt(input logic [31:0] x);
      return {x[30:0], ~(x[31] ^ x[21] ^ x[1] ^ x[0])};
   endfunction

   state_t            state, state_n;
   logic [31:0]       pred, pred_n;
   logic [RUN_W-1:0]  run, run_n;
   logic [MISS_W-1:0] miss, miss_n;
   logic              locked_n;
   logic              error_n;
   logic              err_inc;
   logic              beat_inc;

   // Next-state logic: hunt for a usable seed, confirm LOCK_CNT predictions,
   // then free-run the predictor and track consecutive misses.
   always_comb begin
      state_n  = state;
      pred_n   = pred;
      run_n    = run;
      miss_n   = miss;
      locked_n = locked;
      error_n  = 1'b0;
      err_inc  = 1'b0;
      beat_inc = 1'b0;
      if (valid) begin
         case (state)
            HUNT: begin
               // The all-ones word is the XNOR lock-up state and cannot seed.
               if (data != '1) begin
                  pred_n  = nxt(data);
                  run_n   = '0;
                  state_n = SYNC;
               end
            end
            SYNC: begin
               if (data == pred) begin
                  pred_n = nxt(data);
                  run_n  = run + RUN_W'(1);
                  if ((32'(run) + 32'd1) == LOCK_U) begin
                     state_n  = LOCKED;
                     locked_n = 1'b1;
                     miss_n   = '0;
                  end
               end else begin
                  pred_n = nxt(data);
                  run_n  = '0;
                  if (data == '1) begin
                     state_n = HUNT;
                  end
               end
            end
            LOCKED: begin
               // Predictor free-runs so a bad word cannot poison later checks.
               pred_n   = nxt(pred);
               beat_inc = 1'b1;
               if (data == pred) begin
                  miss_n = '0;
               end else begin
                  error_n = 1'b1;
                  err_inc = 1'b1;
                  miss_n  = miss + MISS_W'(1);
                  if ((32'(miss) + 32'd1) == UNLOCK_U) begin
                     state_n  = HUNT;
                     locked_n = 1'b0;
                  end
               end
            end
            default: begin
               state_n  = HUNT;
               locked_n = 1'b0;
            end
         endcase
      end
   end

   // FSM and predictor registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= HUNT;
         pred   <= '0;
         run    <= '0;
         miss   <= '0;
         locked <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= state_n;
         pred   <= pred_n;
         run    <= run_n;
         miss   <= miss_n;
         locked <= locked_n;
         error  <= error_n;
      end
   end

   // Statistics counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         err_count  <= '0;
         beat_count <= '0;
      end else begin
         if (err_inc && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
         end
         if (beat_inc) begin
            beat_count <= beat_count + 32'd1;
         end
      end
   end

   assign dbg_state = state;

endmodule
